// File: rtl/pipelined_decoder_if.sv
// Interface bundling the fetch-side, writeback and execute-side signals of the
// pipelined decoder. The 'slave' modport is the decoder's view, the 'master'
// modport is the surrounding pipeline (fetch, writeback and execute).
interface pipelined_decoder_if #(
  parameter int WIDTH = 32
);
  // fetch side
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      instr;
  logic [WIDTH-1:0] pc_in;
  // writeback port into the register bank
  logic             wb_we;
  logic [3:0]       wb_addr;
  logic [WIDTH-1:0] wb_data;
  // execute side
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_opa;
  logic [WIDTH-1:0] out_opb;
  logic [WIDTH-1:0] out_str;
  logic [WIDTH-1:0] out_pc;
  logic [3:0]       out_rd;
  logic [1:0]       out_funtype;
  logic [1:0]       out_funcode;
  logic             out_sel_wb;
  logic             out_mem_rd;
  logic             out_mem_wr;
  logic             out_cache_wr;
  logic             out_cache_sh;
  logic             out_branch;

  modport master (
    output in_valid, instr, pc_in, wb_we, wb_addr, wb_data, out_ready,
    input  in_ready, out_valid, out_opa, out_opb, out_str, out_pc, out_rd,
           out_funtype, out_funcode, out_sel_wb, out_mem_rd, out_mem_wr,
           out_cache_wr, out_cache_sh, out_branch
  );

  modport slave (
    input  in_valid, instr, pc_in, wb_we, wb_addr, wb_data, out_ready,
    output in_ready, out_valid, out_opa, out_opb, out_str, out_pc, out_rd,
           out_funtype, out_funcode, out_sel_wb, out_mem_rd, out_mem_wr,
           out_cache_wr, out_cache_sh, out_branch
  );
endinterface

// File: rtl/pipelined_decoder.sv
// Registered decode stage. Owns the register bank and a per-register
// pending-write scoreboard, stalls fetch on read-after-write hazards and
// presents a registered decoded bundle to execute with a valid/ready handshake.
// Optional feature macro: DECODE_BYPASS_EN
//   defined   - writeback data is forwarded to operands read in the same cycle,
//               and a source whose last pending write retires this cycle is
//               not treated as a hazard.
//   undefined - no forwarding; a dependent instruction reads the bank the
//               cycle after its writeback.
module pipelined_decoder #(
  parameter int WIDTH  = 32,
  parameter int NREGS  = 16,
  parameter int PC_IDX = 14,
  parameter int PEND_W = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  pipelined_decoder_if.slave bus
);

  localparam logic [3:0]        PC_ADDR   = 4'(PC_IDX);
  localparam logic [PEND_W-1:0] PEND_ZERO = {PEND_W{1'b0}};
  localparam logic [PEND_W-1:0] PEND_ONE  = PEND_W'(1);
  localparam logic [PEND_W-1:0] PEND_MAX  = {PEND_W{1'b1}};
  localparam logic [WIDTH-1:0]  DATA_ZERO = {WIDTH{1'b0}};

  // instruction type encodings
  localparam logic [1:0] FT_REG    = 2'b00;
  localparam logic [1:0] FT_MEM    = 2'b01;
  localparam logic [1:0] FT_BRANCH = 2'b10;
  localparam logic [1:0] FT_KERNEL = 2'b11;

  // Writeback-select flag from type and function code.
  function automatic logic calc_sel_wb(input logic [1:0] ft, input logic [1:0] fc);
    logic res;
    case (ft)
      FT_REG:    res = (fc != 2'b11);
      FT_MEM:    res = (fc == 2'b00);
      FT_BRANCH: res = 1'b1;
      FT_KERNEL: res = (fc[0] == 1'b0);
      default:   res = 1'b0;
    endcase
    return res;
  endfunction

  // Next scoreboard count given an increment and a decrement request.
  function automatic logic [PEND_W-1:0] calc_pend(input logic [PEND_W-1:0] cnt,
                                                  input logic inc, input logic dec);
    logic [PEND_W-1:0] res;
    case ({inc, dec})
      2'b10:   res = cnt + PEND_ONE;
      2'b01:   res = cnt - PEND_ONE;
      default: res = cnt;
    endcase
    return res;
  endfunction

  // state
  logic [WIDTH-1:0]  regs_r [NREGS];
  logic [PEND_W-1:0] pend_r [NREGS];
  logic [PEND_W-1:0] pend_nxt_s [NREGS];

  logic              out_valid_r;
  logic [WIDTH-1:0]  opa_r, opb_r, str_r, pc_r;
  logic [3:0]        rd_out_r;
  logic [1:0]        funtype_r, funcode_r;
  logic              sel_wb_r, mem_rd_r, mem_wr_r, cache_wr_r, cache_sh_r, branch_r;

  // decode
  logic [1:0]        funtype_s, funcode_s;
  logic [3:0]        rd_s, rs_s, rx_s, src_a_s, dest_s;
  logic              selimm_s;
  logic              is_reg_s, is_mem_s, is_branch_s, is_kernel_s;
  logic              sel_wb_s, mem_rd_s, mem_wr_s, cache_wr_s, cache_sh_s;
  logic              opa_zero_s;
  logic [WIDTH-1:0]  imm_s;
  logic [WIDTH-1:0]  val_a_s, val_x_s, val_d_s;
  logic [WIDTH-1:0]  opa_s, opb_s;
  logic              need_a_s, need_x_s, need_d_s;
  logic [NREGS-1:0]  busy_s;
  logic              hazard_s;
  logic              in_ready_s;
  logic              issue_s;

  // Field extraction, control flags and immediate selection.
  always_comb begin
    funtype_s   = bus.instr[31:30];
    funcode_s   = bus.instr[29:28];
    rd_s        = bus.instr[27:24];
    rs_s        = bus.instr[23:20];
    rx_s        = bus.instr[19:16];
    selimm_s    = bus.instr[0];
    is_reg_s    = (funtype_s == FT_REG);
    is_mem_s    = (funtype_s == FT_MEM);
    is_branch_s = (funtype_s == FT_BRANCH);
    is_kernel_s = (funtype_s == FT_KERNEL);
    sel_wb_s    = calc_sel_wb(funtype_s, funcode_s);
    mem_rd_s    = is_mem_s && (funcode_s == 2'b00);
    mem_wr_s    = is_mem_s && (funcode_s == 2'b01);
    cache_wr_s  = is_kernel_s && (funcode_s == 2'b01);
    cache_sh_s  = is_kernel_s && (funcode_s == 2'b10);
    // CMP compares against RD, so RD becomes the A source
    if (is_reg_s && (funcode_s == 2'b11)) begin
      src_a_s = rd_s;
    end else begin
      src_a_s = rs_s;
    end
    // MOV and every kernel op ignore operand A
    opa_zero_s = (is_reg_s && (funcode_s == 2'b10)) || is_kernel_s;
    if (is_reg_s) begin
      imm_s = WIDTH'(bus.instr[19:1]);
    end else if (is_branch_s) begin
      imm_s = WIDTH'(bus.instr[27:0]);
    end else begin
      imm_s = WIDTH'(bus.instr[23:20]);
    end
    // branches write the PC mirror register
    if (is_branch_s) begin
      dest_s = PC_ADDR;
    end else begin
      dest_s = rd_s;
    end
    need_a_s = !opa_zero_s;
    need_x_s = !selimm_s;
    need_d_s = mem_wr_s;
  end

  // Register reads, with optional same-cycle forwarding of writeback data.
  always_comb begin
    val_a_s = regs_r[src_a_s];
    val_x_s = regs_r[rx_s];
    val_d_s = regs_r[rd_s];
`ifdef DECODE_BYPASS_EN
    if (bus.wb_we && (bus.wb_addr == src_a_s)) begin
      val_a_s = bus.wb_data;
    end else begin
      val_a_s = regs_r[src_a_s];
    end
    if (bus.wb_we && (bus.wb_addr == rx_s)) begin
      val_x_s = bus.wb_data;
    end else begin
      val_x_s = regs_r[rx_s];
    end
    if (bus.wb_we && (bus.wb_addr == rd_s)) begin
      val_d_s = bus.wb_data;
    end else begin
      val_d_s = regs_r[rd_s];
    end
`endif
  end

  // Operand muxing.
  always_comb begin
    if (opa_zero_s) begin
      opa_s = DATA_ZERO;
    end else begin
      opa_s = val_a_s;
    end
    if (selimm_s) begin
      opb_s = imm_s;
    end else begin
      opb_s = val_x_s;
    end
  end

  // Per-register busy flag: a register with pending writes cannot be read yet.
  always_comb begin
    busy_s = {NREGS{1'b0}};
    for (int i = 0; i < NREGS; i++) begin
`ifdef DECODE_BYPASS_EN
      // the last outstanding write retiring now is forwarded, so it is not busy
      busy_s[i] = (pend_r[i] != PEND_ZERO) &&
                  !(bus.wb_we && (bus.wb_addr == 4'(i)) && (pend_r[i] == PEND_ONE));
`else
      busy_s[i] = (pend_r[i] != PEND_ZERO);
`endif
    end
  end

  // Hazard detection and the fetch-side handshake.
  always_comb begin
    hazard_s   = (need_a_s && busy_s[src_a_s]) ||
                 (need_x_s && busy_s[rx_s])    ||
                 (need_d_s && busy_s[rd_s])    ||
                 (pend_r[dest_s] == PEND_MAX);
    in_ready_s = (!out_valid_r || bus.out_ready) && !hazard_s;
    issue_s    = bus.in_valid && in_ready_s;
  end

  // Scoreboard next state: +1 on issue of a writer, -1 on a matching writeback.
  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      pend_nxt_s[i] = calc_pend(pend_r[i],
                                issue_s && sel_wb_s && (dest_s == 4'(i)),
                                bus.wb_we && (bus.wb_addr == 4'(i)) && (pend_r[i] != PEND_ZERO));
    end
  end

  // Scoreboard counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        pend_r[i] <= PEND_ZERO;
      end
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        pend_r[i] <= pend_nxt_s[i];
      end
    end
  end

  // Register bank: writeback, and the PC mirror refreshed every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_r[i] <= DATA_ZERO;
      end
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (bus.wb_we && (bus.wb_addr == 4'(i))) begin
          regs_r[i] <= bus.wb_data;
        end else if (i == PC_IDX) begin
          regs_r[i] <= bus.pc_in;
        end else begin
          regs_r[i] <= regs_r[i];
        end
      end
    end
  end

  // Output bundle: load on issue, drop valid when consumed, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      opa_r       <= DATA_ZERO;
      opb_r       <= DATA_ZERO;
      str_r       <= DATA_ZERO;
      pc_r        <= DATA_ZERO;
      rd_out_r    <= 4'd0;
      funtype_r   <= 2'd0;
      funcode_r   <= 2'd0;
      sel_wb_r    <= 1'b0;
      mem_rd_r    <= 1'b0;
      mem_wr_r    <= 1'b0;
      cache_wr_r  <= 1'b0;
      cache_sh_r  <= 1'b0;
      branch_r    <= 1'b0;
    end else if (issue_s) begin
      out_valid_r <= 1'b1;
      opa_r       <= opa_s;
      opb_r       <= opb_s;
      str_r       <= val_d_s;
      pc_r        <= bus.pc_in;
      rd_out_r    <= dest_s;
      funtype_r   <= funtype_s;
      funcode_r   <= funcode_s;
      sel_wb_r    <= sel_wb_s;
      mem_rd_r    <= mem_rd_s;
      mem_wr_r    <= mem_wr_s;
      cache_wr_r  <= cache_wr_s;
      cache_sh_r  <= cache_sh_s;
      branch_r    <= is_branch_s;
    end else if (bus.out_ready) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  assign bus.in_ready     = in_ready_s;
  assign bus.out_valid    = out_valid_r;
  assign bus.out_opa      = opa_r;
  assign bus.out_opb      = opb_r;
  assign bus.out_str      = str_r;
  assign bus.out_pc       = pc_r;
  assign bus.out_rd       = rd_out_r;
  assign bus.out_funtype  = funtype_r;
  assign bus.out_funcode  = funcode_r;
  assign bus.out_sel_wb   = sel_wb_r;
  assign bus.out_mem_rd   = mem_rd_r;
  assign bus.out_mem_wr   = mem_wr_r;
  assign bus.out_cache_wr = cache_wr_r;
  assign bus.out_cache_sh = cache_sh_r;
  assign bus.out_branch   = branch_r;

endmodule
